xcorr_sync_ctrl: RTL and testbench
==================================

# xcorr_sync_ctrl

Sequencer for the preamble cross-correlator core. Applies bandwidth, threshold and delay configuration through a request/acknowledge handshake, and resets and warms the core. It searches for a first correlation peak, confirms it with a second peak one frame later, then tracks frame timing with a flywheel counter. It sits between the modem control registers and the correlator, and feeds `frame_sop` and the captured peak to the demodulator.

## Interface
- `FRAME_LEN`, 16'd8192: expected cycles between consecutive `osop` pulses.
- `TOL`, 16'd8: half-width of the acceptance window around `FRAME_LEN`.
- `MISS_MAX`, 8'd4: consecutive flywheel misses in LOCK that force a return to SEARCH.
- `RST_LEN`, 4: cycles `xc_rst` is held high at the start of FLUSH.
- `WARM`, 1026: cycles after `xc_rst` falls during which `xc_osop` is ignored.
- `SEARCH_TO`, 32'd1_000_000: SEARCH cycles without a peak before a re-flush.
- `THR_DEF`, 24'd4096: threshold loaded at reset.
- `clk`, in, 1: single clock.
- `rst`, in, 1: one clock; reset is asynchronous and active-low.
- `en`, in, 1: enables acquisition; low forces IDLE.
- `cfg_req`, in, 1: configuration request; held high until `cfg_ack`.
- `cfg_bw`, in, 3: bandwidth index.
- `cfg_thr`, in, 24: detection threshold.
- `cfg_shft`, in, 14: delay-line shift.
- `cfg_ack`, out, 1: one-cycle pulse when the configuration is latched.
- `xc_rst`, out, 1: synchronous active-high reset to the correlator core.
- `xc_index_bw`, out, 3: bandwidth index driven to the core.
- `xc_thr_lvl`, out, 24: threshold driven to the core.
- `xc_addr_shft`, out, 14: delay-line shift driven to the core.
- `xc_osop`, in, 1: peak strobe from the core.
- `xc_peak_i`, in, 18: peak I value, valid with `xc_osop`.
- `xc_peak_q`, in, 18: peak Q value, valid with `xc_osop`.
- `sync_lock`, out, 1: high while in LOCK.
- `frame_sop`, out, 1: one-cycle pulse at each accepted or flywheel frame start.
- `peak_i`, out, 18: last accepted peak I value.
- `peak_q`, out, 18: last accepted peak Q value.
- `miss_cnt`, out, 8: saturating count of consecutive misses.
- `state`, out, 3: current state encoding.

## Operation
- States: IDLE=0, FLUSH=1, SEARCH=2, CONFIRM=3, LOCK=4.
- IDLE:
  - `xc_rst`=1.
  - `en`=1 → FLUSH.
- FLUSH:
  - Counter `fc` runs 0..RST_LEN+WARM-1.
  - `xc_rst`=1 while `fc`<RST_LEN.
  - At terminal count → SEARCH.
  - `xc_osop` is ignored.
- SEARCH:
  - `xc_osop` → CONFIRM, with `frm_cnt`←0 and peak captured.
  - Timeout counter reaches SEARCH_TO-1 → FLUSH.
- CONFIRM:
  - `xc_osop` with `frm_cnt` in [FRAME_LEN-TOL, FRAME_LEN+TOL] → LOCK, `frm_cnt`←0, `frame_sop` pulse.
  - `xc_osop` with `frm_cnt` < FRAME_LEN-TOL → stay in CONFIRM as a new candidate; `frm_cnt`←0; peak recaptured.
  - `frm_cnt` = FRAME_LEN+TOL with no `xc_osop` → SEARCH.
- LOCK:
  - Accepted `xc_osop` (in window): `frm_cnt`←0, `miss_cnt`←0, peak captured, `frame_sop` pulse.
  - `frm_cnt` = FRAME_LEN+TOL with no `xc_osop`: miss, flywheel.
    - `frm_cnt`←TOL, so the next window is centred as if the peak had arrived at FRAME_LEN.
    - `miss_cnt`+1 (saturating at 255).
    - `frame_sop` pulse.
  - `miss_cnt` reaching MISS_MAX → SEARCH; `sync_lock` drops on the same edge.
  - `xc_osop` outside the window is ignored.
- Configuration:
  - `cfg_req` is sampled in every state.
  - Registers latch, and `cfg_ack` pulses on the next edge.
  - If `en`=1, the next state is FLUSH.
  - `xc_index_bw`/`xc_thr_lvl`/`xc_addr_shft` update on the same edge as `cfg_ack`.
  - `cfg_req` must drop after `cfg_ack`. A request still high on the cycle after `cfg_ack` is a new request.
- Priority, highest first: `en`=0 (→IDLE, `miss_cnt`←0), `cfg_req`, `xc_osop`/window events.
- Counters: `frm_cnt` is 16 bit and never wraps; FRAME_LEN+TOL ≤ 65535 is checked at elaboration.

## Timing
- Reset values:
  - `state`=IDLE, `xc_rst`=1.
  - `xc_index_bw`=0, `xc_thr_lvl`=THR_DEF, `xc_addr_shft`=0.
  - `cfg_ack`, `sync_lock`, `frame_sop`, `peak_i`, `peak_q`, `miss_cnt` all 0.
- All outputs are registered.
- `xc_osop` at edge t → state change, `frame_sop`, `peak_i`/`peak_q` (sampled at t) visible after edge t+1.
- `cfg_req` high at t → `cfg_ack` and new `xc_*` values after t+1.
- FLUSH lasts exactly RST_LEN+WARM cycles.
- Asynchronous reset mid-operation returns to the reset values immediately. Leaving reset takes one edge of synchronous deassertion.

## Structure
- `xcorr_ctrl_pkg` holds:
  - the state enum `xc_state_t`;
  - default constants for FRAME_LEN, TOL, MISS_MAX, WARM and THR_DEF;
  - the width localparams (frame counter 16 bit, threshold 24 bit, shift 14 bit).
- Sub-module `xcorr_frame_win` holds `frm_cnt`, the window compare and the flywheel reload.
  - Inputs: `clr`, `osop`.
  - Outputs: `in_win`, `early`, `late`.

## Test plan
Bench parameters: FRAME_LEN=100, TOL=4, MISS_MAX=3, RST_LEN=4, WARM=20, SEARCH_TO=500.

1. Reset release, then `en`=1 → `xc_rst` is high for 4 cycles, FLUSH lasts 24 cycles, then `state`=2.
2. Peak at SEARCH, second peak 98 cycles later → `state`=4 and `sync_lock`=1 one cycle after the second peak; `peak_i` equals the second peak's value.
3. In LOCK, drop peaks:
   - `frame_sop` flywheels at 104 cycles, then every 100 cycles;
   - `miss_cnt` counts 1, 2, 3;
   - at the third miss, `state`=2 and `sync_lock`=0.
4. `cfg_req` with `cfg_bw`=5 arrives in the same cycle as an accepted `osop` → `cfg_ack` pulses once, `xc_index_bw`=5, `state`=1, and no `frame_sop`.
5. SEARCH with no peak for 500 cycles → re-FLUSH, and `xc_rst` pulses again.
6. `rst` asserted mid-LOCK → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/xcorr_ctrl_pkg.sv
// Shared types, widths and default constants for the cross-correlator sync controller.
package xcorr_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FLUSH   = 3'd1,
        ST_SEARCH  = 3'd2,
        ST_CONFIRM = 3'd3,
        ST_LOCK    = 3'd4
    } xc_state_t;

    localparam int FRM_W  = 16;
    localparam int THR_W  = 24;
    localparam int SHFT_W = 14;
    localparam int BW_W   = 3;
    localparam int PEAK_W = 18;
    localparam int MISS_W = 8;
    localparam int TMR_W  = 32;

    localparam logic [FRM_W-1:0]  FRAME_LEN_DEF = 16'd8192;
    localparam logic [FRM_W-1:0]  TOL_DEF       = 16'd8;
    localparam logic [MISS_W-1:0] MISS_MAX_DEF  = 8'd4;
    localparam int unsigned       RST_LEN_DEF   = 4;
    localparam int unsigned       WARM_DEF      = 1026;
    localparam logic [TMR_W-1:0]  SEARCH_TO_DEF = 32'd1_000_000;
    localparam logic [THR_W-1:0]  THR_DEF_VAL   = 24'd4096;

    function automatic logic [MISS_W-1:0] sat_inc(input logic [MISS_W-1:0] v);
        return (v == {MISS_W{1'b1}}) ? v : v + MISS_W'(1);
    endfunction

endpackage

// File: rtl/xcorr_frame_win.sv
// Frame-period counter with acceptance window around FRAME_LEN and flywheel reload.
module xcorr_frame_win
    import xcorr_ctrl_pkg::*;
#(
    parameter logic [FRM_W-1:0] FRAME_LEN = FRAME_LEN_DEF,
    parameter logic [FRM_W-1:0] TOL       = TOL_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic osop,
    output logic in_win,
    output logic early,
    output logic late
);

    localparam logic [FRM_W:0] WIN_LO = {1'b0, FRAME_LEN} - {1'b0, TOL};
    localparam logic [FRM_W:0] WIN_HI = {1'b0, FRAME_LEN} + {1'b0, TOL};

    if (WIN_HI[FRM_W] != 1'b0) begin : g_win_ovf
        $error("FRAME_LEN + TOL must fit in the 16-bit frame counter");
    end
    if (TOL > FRAME_LEN) begin : g_tol_big
        $error("TOL must not exceed FRAME_LEN");
    end

    logic [FRM_W-1:0] frm_cnt;
    logic [FRM_W:0]   elapsed;

    // Windows are judged on cycles since the anchoring edge, counting the current one.
    assign elapsed = {1'b0, frm_cnt} + (FRM_W+1)'(1);
    assign in_win  = (elapsed >= WIN_LO) && (elapsed <= WIN_HI);
    assign early   = (elapsed < WIN_LO);
    assign late    = (elapsed == WIN_HI);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frm_cnt <= '0;
        end else if (clr) begin
            frm_cnt <= '0;
        end else if (late && !osop) begin
            frm_cnt <= TOL;
        end else if ({1'b0, frm_cnt} != WIN_HI) begin
            frm_cnt <= frm_cnt + FRM_W'(1);
        end
    end

endmodule

// File: rtl/xcorr_sync_ctrl.sv
// Sequencer for the preamble cross-correlator: configuration, flush/warm-up,
// two-peak acquisition and flywheel frame tracking.
// state   | meaning
// IDLE    | core held in reset, waiting for en
// FLUSH   | core reset pulse then warm-up, peaks ignored
// SEARCH  | waiting for a first peak, re-flush on timeout
// CONFIRM | candidate peak held, expecting the next one a frame later
// LOCK    | tracking frames, flywheeling through missed peaks
module xcorr_sync_ctrl
    import xcorr_ctrl_pkg::*;
#(
    parameter logic [FRM_W-1:0]  FRAME_LEN = FRAME_LEN_DEF,
    parameter logic [FRM_W-1:0]  TOL       = TOL_DEF,
    parameter logic [MISS_W-1:0] MISS_MAX  = MISS_MAX_DEF,
    parameter int unsigned       RST_LEN   = RST_LEN_DEF,
    parameter int unsigned       WARM      = WARM_DEF,
    parameter logic [TMR_W-1:0]  SEARCH_TO = SEARCH_TO_DEF,
    parameter logic [THR_W-1:0]  THR_DEF   = THR_DEF_VAL
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                cfg_req,
    input  logic [BW_W-1:0]     cfg_bw,
    input  logic [THR_W-1:0]    cfg_thr,
    input  logic [SHFT_W-1:0]   cfg_shft,
    output logic                cfg_ack,
    output logic                xc_rst,
    output logic [BW_W-1:0]     xc_index_bw,
    output logic [THR_W-1:0]    xc_thr_lvl,
    output logic [SHFT_W-1:0]   xc_addr_shft,
    input  logic                xc_osop,
    input  logic [PEAK_W-1:0]   xc_peak_i,
    input  logic [PEAK_W-1:0]   xc_peak_q,
    output logic                sync_lock,
    output logic                frame_sop,
    output logic [PEAK_W-1:0]   peak_i,
    output logic [PEAK_W-1:0]   peak_q,
    output logic [MISS_W-1:0]   miss_cnt,
    output logic [2:0]          state
);

    localparam logic [TMR_W-1:0] FLUSH_TC = TMR_W'(RST_LEN + WARM - 1);
    localparam logic [TMR_W-1:0] SRCH_TC  = SEARCH_TO - TMR_W'(1);
    localparam logic [TMR_W-1:0] RST_TC   = TMR_W'(RST_LEN);

    xc_state_t          st, nxt;
    logic [TMR_W-1:0]   tmr, tmr_nxt;
    logic [MISS_W-1:0]  miss_nxt;
    logic               sop_nxt, cap, win_clr, xc_rst_nxt;
    logic               in_win, early, late;

    xcorr_frame_win #(
        .FRAME_LEN (FRAME_LEN),
        .TOL       (TOL)
    ) u_win (
        .clk    (clk),
        .rst    (rst),
        .clr    (win_clr),
        .osop   (xc_osop),
        .in_win (in_win),
        .early  (early),
        .late   (late)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st  <= ST_IDLE;
            tmr <= '0;
        end else begin
            st  <= nxt;
            tmr <= tmr_nxt;
        end
    end

    always_comb begin
        nxt      = st;
        tmr_nxt  = tmr + TMR_W'(1);
        miss_nxt = miss_cnt;
        sop_nxt  = 1'b0;
        cap      = 1'b0;
        win_clr  = 1'b0;
        if (!en) begin
            nxt      = ST_IDLE;
            miss_nxt = '0;
        end else if (cfg_req) begin
            nxt = ST_FLUSH;
        end else begin
            case (st)
                ST_IDLE:  nxt = ST_FLUSH;
                ST_FLUSH: if (tmr == FLUSH_TC) nxt = ST_SEARCH;
                ST_SEARCH: begin
                    if (xc_osop) begin
                        nxt     = ST_CONFIRM;
                        win_clr = 1'b1;
                        cap     = 1'b1;
                    end else if (tmr == SRCH_TC) begin
                        nxt = ST_FLUSH;
                    end
                end
                ST_CONFIRM: begin
                    if (xc_osop && in_win) begin
                        nxt     = ST_LOCK;
                        win_clr = 1'b1;
                        cap     = 1'b1;
                        sop_nxt = 1'b1;
                    end else if (xc_osop && early) begin
                        win_clr = 1'b1;
                        cap     = 1'b1;
                    end else if (late) begin
                        nxt = ST_SEARCH;
                    end
                end
                ST_LOCK: begin
                    if (xc_osop && in_win) begin
                        win_clr  = 1'b1;
                        cap      = 1'b1;
                        sop_nxt  = 1'b1;
                        miss_nxt = '0;
                    end else if (late) begin
                        sop_nxt  = 1'b1;
                        miss_nxt = sat_inc(miss_cnt);
                        if (miss_nxt >= MISS_MAX) nxt = ST_SEARCH;
                    end
                end
                default: nxt = ST_IDLE;
            endcase
        end
        // A request in FLUSH restarts the flush even though the state is unchanged.
        if ((nxt != st) || (en && cfg_req)) tmr_nxt = '0;
        xc_rst_nxt = (nxt == ST_IDLE) || ((nxt == ST_FLUSH) && (tmr_nxt < RST_TC));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xc_rst       <= 1'b1;
            cfg_ack      <= 1'b0;
            xc_index_bw  <= '0;
            xc_thr_lvl   <= THR_DEF;
            xc_addr_shft <= '0;
            sync_lock    <= 1'b0;
            frame_sop    <= 1'b0;
            peak_i       <= '0;
            peak_q       <= '0;
            miss_cnt     <= '0;
        end else begin
            xc_rst    <= xc_rst_nxt;
            cfg_ack   <= cfg_req;
            sync_lock <= (nxt == ST_LOCK);
            frame_sop <= sop_nxt;
            miss_cnt  <= miss_nxt;
            if (cfg_req) begin
                xc_index_bw  <= cfg_bw;
                xc_thr_lvl   <= cfg_thr;
                xc_addr_shft <= cfg_shft;
            end
            if (cap) begin
                peak_i <= xc_peak_i;
                peak_q <= xc_peak_q;
            end
        end
    end

    assign state = st;

endmodule

// File: tb/tb_xcorr_sync_ctrl.sv
// Bench for xcorr_sync_ctrl: directed acquisition scenarios plus randomized traffic,
// every cycle compared against a timestamp-based reference model.
module tb_xcorr_sync_ctrl;

    localparam int FL = 100, TL = 4, MM = 3, RL = 4, WM = 20, STO = 500;
    localparam int LO = FL - TL, HI = FL + TL;
    localparam int S_IDLE = 0, S_FLUSH = 1, S_SEARCH = 2, S_CONFIRM = 3, S_LOCK = 4;

    logic        clk = 1'b0, rst = 1'b0, en = 1'b0, cfg_req = 1'b0;
    logic [2:0]  cfg_bw = '0;
    logic [23:0] cfg_thr = '0;
    logic [13:0] cfg_shft = '0;
    logic        xc_osop = 1'b0;
    logic [17:0] xc_peak_i = '0, xc_peak_q = '0;
    logic        cfg_ack, xc_rst, sync_lock, frame_sop;
    logic [2:0]  xc_index_bw, state;
    logic [23:0] xc_thr_lvl;
    logic [13:0] xc_addr_shft;
    logic [17:0] peak_i, peak_q;
    logic [7:0]  miss_cnt;

    xcorr_sync_ctrl #(
        .FRAME_LEN (16'd100),
        .TOL       (16'd4),
        .MISS_MAX  (8'd3),
        .RST_LEN   (4),
        .WARM      (20),
        .SEARCH_TO (32'd500)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .cfg_req      (cfg_req),
        .cfg_bw       (cfg_bw),
        .cfg_thr      (cfg_thr),
        .cfg_shft     (cfg_shft),
        .cfg_ack      (cfg_ack),
        .xc_rst       (xc_rst),
        .xc_index_bw  (xc_index_bw),
        .xc_thr_lvl   (xc_thr_lvl),
        .xc_addr_shft (xc_addr_shft),
        .xc_osop      (xc_osop),
        .xc_peak_i    (xc_peak_i),
        .xc_peak_q    (xc_peak_q),
        .sync_lock    (sync_lock),
        .frame_sop    (frame_sop),
        .peak_i       (peak_i),
        .peak_q       (peak_q),
        .miss_cnt     (miss_cnt),
        .state        (state)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: timestamps of state entry and of the frame anchor.
    int          cyc = 0;
    int          m_st, m_enter, m_anchor, m_miss;
    bit          m_sop, m_ack;
    logic [17:0] m_pi, m_pq;
    logic [2:0]  m_bw;
    logic [23:0] m_thr;
    logic [13:0] m_shft;

    task automatic model_reset();
        m_st = S_IDLE; m_enter = cyc; m_anchor = cyc; m_miss = 0;
        m_sop = 0; m_ack = 0; m_pi = '0; m_pq = '0;
        m_bw = '0; m_thr = 24'd4096; m_shft = '0;
    endtask

    task automatic anchor_peak();
        m_anchor = cyc;
        m_pi = xc_peak_i;
        m_pq = xc_peak_q;
    endtask

    task automatic model_step();
        int nst, age;
        bit restart;
        cyc++;
        nst = m_st;
        restart = 0;
        age = cyc - m_anchor;
        m_sop = 0;
        m_ack = cfg_req;
        if (cfg_req) begin
            m_bw = cfg_bw; m_thr = cfg_thr; m_shft = cfg_shft;
        end
        if (!en) begin
            nst = S_IDLE;
            m_miss = 0;
        end else if (cfg_req) begin
            nst = S_FLUSH;
            restart = 1;
        end else begin
            case (m_st)
                S_IDLE: nst = S_FLUSH;
                S_FLUSH: if (cyc - m_enter == RL + WM) nst = S_SEARCH;
                S_SEARCH: begin
                    if (xc_osop) begin nst = S_CONFIRM; anchor_peak(); end
                    else if (cyc - m_enter == STO) nst = S_FLUSH;
                end
                S_CONFIRM: begin
                    if (xc_osop && age >= LO && age <= HI) begin
                        nst = S_LOCK; anchor_peak(); m_sop = 1;
                    end else if (xc_osop && age < LO) begin
                        anchor_peak();
                    end else if (age == HI) begin
                        nst = S_SEARCH;
                    end
                end
                default: begin
                    if (xc_osop && age >= LO && age <= HI) begin
                        anchor_peak(); m_miss = 0; m_sop = 1;
                    end else if (age == HI) begin
                        m_anchor = cyc - TL;
                        if (m_miss < 255) m_miss++;
                        m_sop = 1;
                        if (m_miss >= MM) nst = S_SEARCH;
                    end
                end
            endcase
        end
        if (nst != m_st || restart) m_enter = cyc;
        m_st = nst;
    endtask

    task automatic compare_all();
        chk_eq("state", state, m_st);
        chk_eq("xc_rst", xc_rst, (m_st == S_IDLE) || (m_st == S_FLUSH && cyc - m_enter < RL));
        chk_eq("sync_lock", sync_lock, m_st == S_LOCK);
        chk_eq("frame_sop", frame_sop, m_sop);
        chk_eq("cfg_ack", cfg_ack, m_ack);
        chk_eq("xc_index_bw", xc_index_bw, m_bw);
        chk_eq("xc_thr_lvl", xc_thr_lvl, m_thr);
        chk_eq("xc_addr_shft", xc_addr_shft, m_shft);
        chk_eq("peak_i", peak_i, m_pi);
        chk_eq("peak_q", peak_q, m_pq);
        chk_eq("miss_cnt", miss_cnt, m_miss);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle_ticks(input int n);
        xc_osop = 1'b0;
        cfg_req = 1'b0;
        repeat (n) tick();
    endtask

    task automatic peak(input logic [17:0] pi, input logic [17:0] pq);
        xc_osop = 1'b1; xc_peak_i = pi; xc_peak_q = pq;
        tick();
        xc_osop = 1'b0;
    endtask

    task automatic wait_state(input int s, input int max_cyc, input string tag);
        int k = 0;
        while (state != 3'(s) && k < max_cyc) begin tick(); k++; end
        chk_eq(tag, state, s);
    endtask

    task automatic check_reset_vals(input string tag);
        chk_eq({tag, "_state"}, state, S_IDLE);
        chk_eq({tag, "_xc_rst"}, xc_rst, 1);
        chk_eq({tag, "_bw"}, xc_index_bw, 0);
        chk_eq({tag, "_thr"}, xc_thr_lvl, 24'd4096);
        chk_eq({tag, "_shft"}, xc_addr_shft, 0);
        chk_eq({tag, "_ack"}, cfg_ack, 0);
        chk_eq({tag, "_lock"}, sync_lock, 0);
        chk_eq({tag, "_sop"}, frame_sop, 0);
        chk_eq({tag, "_pi"}, peak_i, 0);
        chk_eq({tag, "_pq"}, peak_q, 0);
        chk_eq({tag, "_miss"}, miss_cnt, 0);
    endtask

    initial begin
        int fl, rc, k, lock_t, next_pk;
        int sop_t[$];
        int sop_m[$];

        // 1: reset, then flush timing
        #12 check_reset_vals("rst0");
        @(negedge clk) rst = 1'b1;
        model_reset();
        idle_ticks(2);
        en = 1'b1;
        tick();
        fl = 0; rc = 0;
        while (state == 3'd1 && fl < 40) begin
            fl++;
            if (xc_rst) rc++;
            tick();
        end
        chk_eq("t1_flush_len", fl, 24);
        chk_eq("t1_rst_len", rc, 4);
        chk_eq("t1_state", state, S_SEARCH);

        // 2: two-peak acquisition
        idle_ticks(3);
        peak(18'h1234A, 18'h2ABCD);
        idle_ticks(97);
        peak(18'h0F0F0, 18'h30303);
        chk_eq("t2_state", state, S_LOCK);
        chk_eq("t2_lock", sync_lock, 1);
        chk_eq("t2_peak_i", peak_i, 18'h0F0F0);
        lock_t = cyc;

        // 3: flywheel through dropped peaks
        for (int i = 0; i < 400 && state != 3'd2; i++) begin
            tick();
            if (frame_sop) begin sop_t.push_back(cyc); sop_m.push_back(int'(miss_cnt)); end
        end
        chk_eq("t3_sop_count", sop_t.size(), 3);
        if (sop_t.size() == 3) begin
            chk_eq("t3_first_gap", sop_t[0] - lock_t, 104);
            chk_eq("t3_gap2", sop_t[1] - sop_t[0], 100);
            chk_eq("t3_gap3", sop_t[2] - sop_t[1], 100);
            chk_eq("t3_miss1", sop_m[0], 1);
            chk_eq("t3_miss2", sop_m[1], 2);
            chk_eq("t3_miss3", sop_m[2], 3);
        end
        chk_eq("t3_state", state, S_SEARCH);
        chk_eq("t3_lock", sync_lock, 0);

        // 4: config request colliding with an accepted peak
        peak(18'h00111, 18'h00222);
        idle_ticks(99);
        peak(18'h00333, 18'h00444);
        chk_eq("t4_locked", state, S_LOCK);
        idle_ticks(99);
        cfg_req = 1'b1; cfg_bw = 3'd5; cfg_thr = 24'h00ABCD; cfg_shft = 14'h155;
        xc_osop = 1'b1; xc_peak_i = 18'h3FFFF;
        tick();
        cfg_req = 1'b0; xc_osop = 1'b0;
        chk_eq("t4_ack", cfg_ack, 1);
        chk_eq("t4_bw", xc_index_bw, 5);
        chk_eq("t4_state", state, S_FLUSH);
        chk_eq("t4_no_sop", frame_sop, 0);
        tick();
        chk_eq("t4_ack_single", cfg_ack, 0);

        // 5: search timeout re-flushes the core
        wait_state(S_SEARCH, 40, "t5_search");
        k = 0;
        while (state == 3'd2 && k < 600) begin tick(); k++; end
        chk_eq("t5_search_len", k, STO);
        chk_eq("t5_state", state, S_FLUSH);
        chk_eq("t5_xc_rst", xc_rst, 1);

        // 6: asynchronous reset while locked
        wait_state(S_SEARCH, 40, "t6_search");
        peak(18'h00555, 18'h00666);
        idle_ticks(99);
        peak(18'h00777, 18'h00888);
        idle_ticks(10);
        chk_eq("t6_locked", state, S_LOCK);
        #2 rst = 1'b0;
        #1 check_reset_vals("t6");
        @(negedge clk) rst = 1'b1;
        model_reset();

        // randomized traffic: jittered frames, drops, spurious peaks, configs, enable drops
        next_pk = cyc + 40;
        for (int i = 0; i < 6000; i++) begin
            en       = ($urandom_range(0, 799) != 0);
            cfg_req  = ($urandom_range(0, 499) == 0);
            cfg_bw   = 3'($urandom);
            cfg_thr  = 24'($urandom);
            cfg_shft = 14'($urandom);
            xc_peak_i = 18'($urandom);
            xc_peak_q = 18'($urandom);
            xc_osop  = 1'b0;
            if (cyc + 1 >= next_pk) begin
                xc_osop = ($urandom_range(0, 7) != 0);
                next_pk = cyc + 1 + 94 + int'($urandom_range(0, 12));
            end else if ($urandom_range(0, 299) == 0) begin
                xc_osop = 1'b1;
            end
            tick();
        end
        idle_ticks(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
